random_number_counter: RTL and testbench

//   Free-running pseudo-random number generator built on a maximal-length

---
 rtl/random_number_counter_pkg.sv | 32 +++
 rtl/random_number_counter_lfsr_next.sv | 22 ++
 rtl/random_number_counter.sv | 43 ++++
 tb/tb_random_number_counter.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/random_number_counter_pkg.sv
// Shared constants and the primitive-polynomial tap table for the
// Fibonacci LFSR random source.
package random_counter_pkg;

  localparam int MIN_WIDTH = 3;
  localparam int MAX_WIDTH = 16;

  // Bit i set means state[i] feeds the XOR; polynomials are maximal-length.
  function automatic logic [15:0] lfsr_taps(input int width);
    logic [15:0] t;
    t = 16'h0000;
    case (width)
      3:  t = 16'h0006;
      4:  t = 16'h000C;
      5:  t = 16'h0014;
      6:  t = 16'h0030;
      7:  t = 16'h0060;
      8:  t = 16'h00B8;
      9:  t = 16'h0110;
      10: t = 16'h0240;
      11: t = 16'h0500;
      12: t = 16'h0829;
      13: t = 16'h100D;
      14: t = 16'h2015;
      15: t = 16'h6000;
      16: t = 16'hB400;
      default: t = 16'h0000;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/random_number_counter_lfsr_next.sv
// Combinational next-state for a left-shifting Fibonacci LFSR, with a
// reload of the seed when the state has fallen into the all-zero trap.
import random_counter_pkg::*;

module lfsr_next #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_state,
  input  logic [WIDTH-1:0] i_taps,
  input  logic [WIDTH-1:0] i_seed,
  output logic [WIDTH-1:0] o_next
);

  logic w_fb;

  always_comb begin
    w_fb = ^(i_state & i_taps);
    if (i_state == '0) o_next = i_seed;
    else               o_next = {i_state[WIDTH-2:0], w_fb};
  end

endmodule

// File: rtl/random_number_counter.sv
// Free-running maximal-length LFSR; the state register is the output, so the
// value is visible with no extra pipeline stage and resets asynchronously.
import random_counter_pkg::*;

module random_number_counter #(
  parameter int          WIDTH = 4,
  parameter logic [15:0] SEED  = 16'h1
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] number
);

  localparam logic [15:0]      TAPS16 = lfsr_taps(WIDTH);
  localparam logic [15:0]      SEED16 = SEED;
  localparam logic [WIDTH-1:0] TAPS   = TAPS16[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SEEDW  = SEED16[WIDTH-1:0];

  if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("random_number_counter: WIDTH %0d outside %0d..%0d", WIDTH, MIN_WIDTH, MAX_WIDTH);
  end
  if (SEEDW == '0) begin : g_bad_seed
    $error("random_number_counter: SEED is zero when masked to WIDTH");
  end

  logic [WIDTH-1:0] r_state;
  logic [WIDTH-1:0] w_next;

  lfsr_next #(.WIDTH(WIDTH)) u_next (
    .i_state (r_state),
    .i_taps  (TAPS),
    .i_seed  (SEEDW),
    .o_next  (w_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= SEEDW;
    else     r_state <= w_next;
  end

  assign number = r_state;

endmodule

// File: tb/tb_random_number_counter.sv
// Self-checking bench: vector table, period/coverage windows, async reset,
// lock-up recovery, random reset pulses and a width sweep (8 and 3).
module tb_random_number_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] n4;
  logic [7:0] n8;
  logic [2:0] n3;

  int errors = 0;
  int checks = 0;

  random_number_counter #(.WIDTH(4), .SEED(16'h1))  u_w4 (.clk(clk), .rst(rst), .number(n4));
  random_number_counter #(.WIDTH(8), .SEED(16'hA5)) u_w8 (.clk(clk), .rst(rst), .number(n8));
  random_number_counter #(.WIDTH(3), .SEED(16'h1))  u_w3 (.clk(clk), .rst(rst), .number(n3));

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] exp;
  } vec_t;

  logic [3:0] seq [15];
  vec_t       vecs [25];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pos;
    int k;
    logic [15:0] mask;
    bit found;
    bit [255:0] seen8;
    bit [7:0]   seen3;
    int dup8, dup3, zero8, zero3;

    seq = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
            4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};
    for (int i = 0; i < 10; i++) vecs[i] = '{1'b1, 4'h1};
    for (int i = 0; i < 15; i++) vecs[10 + i] = '{1'b0, seq[(i + 1) % 15]};

    // Reset visible before any clock edge.
    #1 rst = 1'b1;
    #1 chk("pre_edge_reset", 16'(n4), 16'h1);

    for (int i = 0; i < 25; i++) begin
      rst = vecs[i].rst;
      tick();
      chk($sformatf("vec%0d", i), 16'(n4), 16'(vecs[i].exp));
    end

    // 200 cycles against the reference sequence; every 15-sample window full.
    pos = 0; mask = '0;
    for (int i = 0; i < 200; i++) begin
      tick();
      pos = (pos + 1) % 15;
      chk("period_seq", 16'(n4), 16'(seq[pos]));
      mask |= 16'(1) << n4;
      if (i % 15 == 14) begin
        chk("window_cover", mask, 16'hFFFE);
        mask = '0;
      end
    end

    // Async reset between edges while showing B.
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      tick();
      if (n4 == 4'hB) found = 1'b1;
    end
    chk("wait_for_B", 16'(found), 16'h1);
    #2 rst = 1'b1;
    #1 chk("async_reset_mid", 16'(n4), 16'h1);
    tick();
    chk("reset_hold", 16'(n4), 16'h1);
    rst = 1'b0;
    tick();
    chk("post_release", 16'(n4), 16'h2);

    // Lock-up: state forced to zero recovers via SEED.
    force u_w4.r_state = 4'h0;
    #1 chk("forced_zero", 16'(n4), 16'h0);
    release u_w4.r_state;
    tick();
    chk("lockup_reload", 16'(n4), 16'h1);
    tick();
    chk("lockup_next", 16'(n4), 16'h2);

    // Random reset pulses against the sequence model.
    pos = 1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        k = $urandom_range(1, 3);
        #2 rst = 1'b1;
        #1 chk("rand_async", 16'(n4), 16'h1);
        for (int j = 0; j < k; j++) begin
          tick();
          chk("rand_hold", 16'(n4), 16'h1);
        end
        rst = 1'b0;
        pos = 0;
      end
      tick();
      pos = (pos + 1) % 15;
      chk("rand_seq", 16'(n4), 16'(seq[pos]));
    end

    // Width sweep: W8 period 255, W3 period 7, no zero.
    rst = 1'b1;
    tick();
    chk("w8_reset", 16'(n8), 16'hA5);
    chk("w3_reset", 16'(n3), 16'h1);
    rst = 1'b0;
    seen8 = '0; seen3 = '0; dup8 = 0; dup3 = 0; zero8 = 0; zero3 = 0;
    seen8[8'hA5] = 1'b1;
    seen3[1] = 1'b1;
    for (int i = 1; i <= 255; i++) begin
      tick();
      if (n8 == 8'h0) zero8++;
      if (n3 == 3'h0) zero3++;
      if (i < 255) begin
        if (seen8[n8]) dup8++;
        seen8[n8] = 1'b1;
      end else begin
        chk("w8_wrap", 16'(n8), 16'hA5);
      end
      if (i < 7) begin
        if (seen3[n3]) dup3++;
        seen3[n3] = 1'b1;
      end else if (i == 7) begin
        chk("w3_wrap", 16'(n3), 16'h1);
      end
    end
    chk("w8_dups", 16'(dup8), 16'h0);
    chk("w8_zero", 16'(zero8), 16'h0);
    chk("w3_dups", 16'(dup3), 16'h0);
    chk("w3_zero", 16'(zero3), 16'h0);
    chk("w3_all", 16'(seen3), 16'h00FE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
